fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-004 SHALL have port imem_addr  output  8  address driven to the instruction memory input.
REQ-005 SHALL have port imem_data  input  8  instruction memory output; holds mem[A] after the edge that sampled imem_addr=A.
REQ-006 SHALL have port id_ready  input  1  decode stage accepts ir this edge.
REQ-007 SHALL have port branch_taken  input  1  redirect fetch to branch_target.
REQ-008 SHALL have port branch_target  input  8  redirect address.
REQ-009 SHALL have port halt  input  1  stop issuing fetches.
REQ-010 SHALL have port ir  output  8  instruction register to decode.
REQ-011 SHALL have port ir_pc  output  8  address ir was fetched from.
REQ-012 SHALL have port ir_valid  output  1  ir holds a valid instruction.
REQ-013 SHALL have port halted  output  1  high in HALTED state.

Function
REQ-014 SHALL keep internal registers: pc[8], req_pc[8], req_valid, state {RUN, HALTED}.
REQ-015 SHALL drive imem_addr = req_pc when hold, else pc; hold = ir_valid & !id_ready (combinational).
REQ-016 SHALL, on an edge with hold=0 and no branch/halt: ir<=imem_data, ir_pc<=req_pc, ir_valid<=req_valid, req_pc<=pc, req_valid<=(state==RUN), pc<=pc+1 only when state==RUN.
REQ-017 SHALL, on an edge with hold=1 and no branch/halt: keep pc, req_pc, req_valid, ir, ir_pc, ir_valid unchanged (memory re-reads req_pc, so imem_data stays stable).
REQ-018 SHALL increment pc modulo 256: 8'hFF -> 8'h00, no flag.
REQ-019 SHALL, on branch_taken=1 in RUN (halt=0): pc<=branch_target, req_valid<=0, ir_valid<=0, regardless of hold.
REQ-020 SHALL produce first valid ir from a branch target 2 edges after the branch edge, ir=mem[target], ir_pc=target.
REQ-021 SHALL, on halt=1 in RUN: state<=HALTED, req_valid<=0, pc unchanged; ir stage advances per REQ-016/017, so an in-flight instruction still drains.
REQ-022 SHALL give halt priority over branch_taken on the same edge; the branch is ignored and nothing is flushed.
REQ-023 SHALL ignore branch_taken and halt in HALTED; HALTED exits only through reset.
REQ-024 SHALL assert halted=1 exactly while state==HALTED.
REQ-025 SHALL present each fetched instruction to decode exactly once; no instruction dropped or duplicated across hold.

Reset
REQ-026 SHALL, while reset=0: pc=RESET_PC, req_pc=0, req_valid=0, ir=0, ir_pc=0, ir_valid=0, state=RUN, halted=0.
REQ-027 SHALL deliver first valid ir 2 rising edges after reset release: edge1 samples addr RESET_PC; edge2 ir=mem[RESET_PC], ir_valid=1.
REQ-028 SHALL abandon any in-flight fetch, hold or halt on reset assertion mid-operation; no partial update after release.

Verification
Memory preload mem[0..3]=8'h11,8'h22,8'h33,8'h44, mem[8'h80]=8'hA5, mem[8'hFF]=8'h5A, mem[8'h00]=8'h11.
REQ-029 Reset release, id_ready=1 -> ir_valid rises at edge 2; ir sequence 11,22,33,44 with ir_pc 0,1,2,3 on consecutive edges.
REQ-030 id_ready=0 for 3 edges while ir=8'h22 -> ir=22, ir_pc=1 held; imem_addr=2 during hold; after release ir=33 then 44, no skip or repeat.
REQ-031 branch_taken=1, branch_target=8'h80 while ir=8'h22 -> next edge ir_valid=0; 2 edges after branch ir=A5, ir_pc=80.
REQ-032 Branch to 8'hFF -> ir=5A (ir_pc=FF) then ir=11 (ir_pc=00): wrap.
REQ-033 halt=1 and branch_taken=1 same edge after ir=11 -> halted=1, ir=22 delivered once, then ir_valid=0 forever; pc not redirected; reset low then high restarts per REQ-029.

Source files
------------

// File: rtl/fetch_unit.sv
// Two-stage instruction fetch: a request stage tracking the address in flight to a
// synchronous instruction memory, and an instruction register presented to decode.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  input  logic       id_ready,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  input  logic       halt,
  output logic [7:0] ir,
  output logic [7:0] ir_pc,
  output logic       ir_valid,
  output logic       halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t     state, state_nxt;
  logic [7:0] pc, req_pc;
  logic       req_valid;
  logic       hold;

  // While decode stalls, the memory re-reads req_pc so imem_data stays stable.
  assign hold      = ir_valid & ~id_ready;
  assign imem_addr = hold ? req_pc : pc;
  assign halted    = (state == HALTED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN && halt) state_nxt = HALTED;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      req_pc    <= 8'h00;
      req_valid <= 1'b0;
      ir        <= 8'h00;
      ir_pc     <= 8'h00;
      ir_valid  <= 1'b0;
    end else if (state == RUN && halt) begin
      // Halt wins over a same-edge branch; the instruction already returned still drains.
      req_valid <= 1'b0;
      if (!hold) begin
        ir       <= imem_data;
        ir_pc    <= req_pc;
        ir_valid <= req_valid;
        req_pc   <= pc;
      end
    end else if (state == RUN && branch_taken) begin
      pc        <= branch_target;
      req_valid <= 1'b0;
      ir_valid  <= 1'b0;
    end else if (!hold) begin
      ir        <= imem_data;
      ir_pc     <= req_pc;
      ir_valid  <= req_valid;
      req_pc    <= pc;
      req_valid <= (state == RUN);
      if (state == RUN) pc <= pc + 8'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a synchronous instruction memory model.
module tb_fetch_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] imem_addr;
  logic [7:0] imem_data = 8'h00;
  logic       id_ready = 1'b1;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       halt = 1'b0;
  logic [7:0] ir, ir_pc;
  logic       ir_valid, halted;

  logic [7:0] mem [256];
  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.RESET_PC(8'h00)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_ready(id_ready), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted)
  );

  always #5 clock = ~clock;

  always @(posedge clock) imem_data <= mem[imem_addr];

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    id_ready = 1'b1; branch_taken = 1'b0; halt = 1'b0; branch_target = 8'h00;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic expect_ir(string name, logic [7:0] e_ir, logic [7:0] e_pc);
    vectors++;
    if (ir_valid !== 1'b1 || ir !== e_ir || ir_pc !== e_pc) begin
      miscompares++;
      $display("FAIL %s: ir=%h ir_pc=%h ir_valid=%b, required ir=%h ir_pc=%h ir_valid=1",
               name, ir, ir_pc, ir_valid, e_ir, e_pc);
    end
  endtask

  task automatic expect_invalid(string name);
    vectors++;
    if (ir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: ir_valid=%b, required 0", name, ir_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    vectors++;
    if (ir !== 8'h00 || ir_pc !== 8'h00 || ir_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: ir=%h ir_pc=%h ir_valid=%b halted=%b imem_addr=%h, required all 0",
               ir, ir_pc, ir_valid, halted, imem_addr);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    tick(); expect_invalid("seq_edge1");
    tick(); expect_ir("seq_edge2", 8'h11, 8'h00);
    tick(); expect_ir("seq_edge3", 8'h22, 8'h01);
    tick(); expect_ir("seq_edge4", 8'h33, 8'h02);
    tick(); expect_ir("seq_edge5", 8'h44, 8'h03);
  endtask

  task automatic test_hold();
    do_reset();
    tick(); tick(); tick();
    expect_ir("hold_pre", 8'h22, 8'h01);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_ir($sformatf("hold_edge%0d", i), 8'h22, 8'h01);
      vectors++;
      if (imem_addr !== 8'h02) begin
        miscompares++;
        $display("FAIL hold_addr%0d: imem_addr=%h, required 02", i, imem_addr);
      end
    end
    id_ready = 1'b1;
    tick(); expect_ir("hold_rel1", 8'h33, 8'h02);
    tick(); expect_ir("hold_rel2", 8'h44, 8'h03);
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick(); tick();
    expect_ir("br_pre", 8'h22, 8'h01);
    branch_taken = 1'b1; branch_target = 8'h80;
    tick(); expect_invalid("br_flush");
    branch_taken = 1'b0;
    tick(); expect_invalid("br_bubble");
    tick(); expect_ir("br_target", 8'hA5, 8'h80);
  endtask

  task automatic test_branch_wrap();
    do_reset();
    tick(); tick();
    expect_ir("wrap_pre", 8'h11, 8'h00);
    id_ready = 1'b0;
    tick(); expect_ir("wrap_hold", 8'h11, 8'h00);
    branch_taken = 1'b1; branch_target = 8'hFF;
    tick(); expect_invalid("wrap_flush_in_hold");
    branch_taken = 1'b0; id_ready = 1'b1;
    tick(); expect_invalid("wrap_bubble");
    tick(); expect_ir("wrap_ff", 8'h5A, 8'hFF);
    tick(); expect_ir("wrap_00", 8'h11, 8'h00);
    tick(); expect_ir("wrap_01", 8'h22, 8'h01);
  endtask

  task automatic test_halt();
    do_reset();
    tick(); tick();
    expect_ir("halt_pre", 8'h11, 8'h00);
    halt = 1'b1; branch_taken = 1'b1; branch_target = 8'h80;
    tick();
    expect_ir("halt_drain", 8'h22, 8'h01);
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_flag: halted=%b, required 1", halted);
    end
    halt = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_invalid($sformatf("halt_idle%0d", i));
      vectors++;
      if (imem_addr !== 8'h02 || halted !== 1'b1) begin
        miscompares++;
        $display("FAIL halt_pc%0d: imem_addr=%h halted=%b, required 02 and 1", i, imem_addr, halted);
      end
    end
    branch_taken = 1'b1; branch_target = 8'h80;
    tick(); tick();
    branch_taken = 1'b0;
    tick();
    expect_invalid("halt_ign_branch");
    vectors++;
    if (imem_addr !== 8'h02 || halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_ign_branch_pc: imem_addr=%h halted=%b, required 02 and 1", imem_addr, halted);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); tick(); tick();
    id_ready = 1'b0;
    tick();
    expect_ir("mid_pre", 8'h22, 8'h01);
    reset = 1'b0;
    #1;
    vectors++;
    if (ir_valid !== 1'b0 || ir !== 8'h00 || halted !== 1'b0 || imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_async: ir=%h ir_valid=%b halted=%b imem_addr=%h, required 00 0 0 00",
               ir, ir_valid, halted, imem_addr);
    end
    test_sequence();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[8'h80] = 8'hA5; mem[8'hFF] = 8'h5A;
    test_reset();
    test_sequence();
    test_hold();
    test_branch();
    test_branch_wrap();
    test_halt();
    do_reset();
    test_sequence();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
